// File: rtl/spi_txn_queue_if.sv
// Host-side command/response channel bundle for spi_txn_queue.
// The host drives commands and accepts responses through the master modport; the queue uses the slave modport.
interface spi_txn_queue_if #(
  parameter int AW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_data;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_len;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [AW-1:0] rsp_addr;

  modport master (
    output cmd_valid, cmd_data, cmd_addr, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_addr, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/spi_txn_queue.sv
// Command/response queue in front of spi_master: buffers host commands, launches them one at a time,
// and returns each received word tagged with its slave address.
module spi_txn_queue #(
  parameter int SLAVE_COUNT = 8,
  parameter int DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  spi_txn_queue_if.slave                 host,
  output logic [$clog2(DEPTH):0]         cmd_count,
  output logic [$clog2(DEPTH):0]         rsp_count,
  output logic                           m_start_trans,
  input  logic                           m_busy,
  output logic [31:0]                    m_tx_data,
  output logic [$clog2(SLAVE_COUNT)-1:0] m_chipADDRS,
  output logic [1:0]                     m_transaction_length,
  input  logic [31:0]                    m_rx_data
);

  localparam int AW = $clog2(SLAVE_COUNT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] CAPTURE   = 3'd4;

  logic [31:0]   cmd_data_q [DEPTH];
  logic [31:0]   cmd_data_d [DEPTH];
  logic [AW-1:0] cmd_addr_q [DEPTH];
  logic [AW-1:0] cmd_addr_d [DEPTH];
  logic [1:0]    cmd_len_q  [DEPTH];
  logic [1:0]    cmd_len_d  [DEPTH];
  logic [PW-1:0] cmd_wr_q, cmd_wr_d;
  logic [PW-1:0] cmd_rd_q, cmd_rd_d;
  logic [CW-1:0] cmd_count_q, cmd_count_d;

  logic [31:0]   rsp_data_q [DEPTH];
  logic [31:0]   rsp_data_d [DEPTH];
  logic [AW-1:0] rsp_addr_q [DEPTH];
  logic [AW-1:0] rsp_addr_d [DEPTH];
  logic [PW-1:0] rsp_wr_q, rsp_wr_d;
  logic [PW-1:0] rsp_rd_q, rsp_rd_d;
  logic [CW-1:0] rsp_count_q, rsp_count_d;

  logic [2:0]    state_q, state_d;
  logic [31:0]   tx_q, tx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    len_q, len_d;

  logic          cmd_ready_w;
  logic          cmd_push;
  logic          rsp_valid_w;
  logic          rsp_pop;
  logic          rsp_push;
  logic          pending;
  logic [CW:0]   rsp_reserved;
  logic          rsp_room;
  logic          launch;

  function automatic logic [31:0] mask_rx(input logic [31:0] d, input logic [1:0] l);
    logic [31:0] r;
    case (l)
      2'b00:   r = {24'h0, d[7:0]};
      2'b01:   r = {16'h0, d[15:0]};
      2'b10:   r = {8'h0, d[23:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign cmd_ready_w  = (cmd_count_q != FULL);
  assign cmd_push     = host.cmd_valid & cmd_ready_w;
  assign rsp_valid_w  = (rsp_count_q != '0);
  assign rsp_pop      = rsp_valid_w & host.rsp_ready;
  assign rsp_push     = (state_q == CAPTURE);

  // A transfer in flight already owns one response slot, so capture can never overflow.
  assign pending      = (state_q != IDLE);
  assign rsp_reserved = {1'b0, rsp_count_q} + (CW+1)'(pending);
  assign rsp_room     = (rsp_reserved < (CW+1)'(DEPTH));

  assign launch = (state_q == IDLE) && enable && (cmd_count_q != '0) && rsp_room && !m_busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (launch) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (m_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!m_busy) state_d = CAPTURE;
      CAPTURE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // The m_* registers double as the pending address/length used when the result is captured.
  always_comb begin
    tx_d   = tx_q;
    addr_d = addr_q;
    len_d  = len_q;
    if (launch) begin
      tx_d   = cmd_data_q[cmd_rd_q];
      addr_d = cmd_addr_q[cmd_rd_q];
      len_d  = cmd_len_q[cmd_rd_q];
    end
  end

  always_comb begin
    cmd_data_d  = cmd_data_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    cmd_wr_d    = cmd_wr_q;
    cmd_rd_d    = cmd_rd_q;
    if (cmd_push) begin
      cmd_data_d[cmd_wr_q] = host.cmd_data;
      cmd_addr_d[cmd_wr_q] = host.cmd_addr;
      cmd_len_d[cmd_wr_q]  = host.cmd_len;
      cmd_wr_d             = cmd_wr_q + 1'b1;
    end
    if (launch) begin
      cmd_rd_d = cmd_rd_q + 1'b1;
    end
    cmd_count_d = cmd_count_q + CW'(cmd_push) - CW'(launch);
  end

  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_wr_d   = rsp_wr_q;
    rsp_rd_d   = rsp_rd_q;
    if (rsp_push) begin
      rsp_data_d[rsp_wr_q] = mask_rx(m_rx_data, len_q);
      rsp_addr_d[rsp_wr_q] = addr_q;
      rsp_wr_d             = rsp_wr_q + 1'b1;
    end
    if (rsp_pop) begin
      rsp_rd_d = rsp_rd_q + 1'b1;
    end
    rsp_count_d = rsp_count_q + CW'(rsp_push) - CW'(rsp_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cmd_data_q[i] <= '0;
        cmd_addr_q[i] <= '0;
        cmd_len_q[i]  <= '0;
        rsp_data_q[i] <= '0;
        rsp_addr_q[i] <= '0;
      end
      cmd_wr_q    <= '0;
      cmd_rd_q    <= '0;
      cmd_count_q <= '0;
      rsp_wr_q    <= '0;
      rsp_rd_q    <= '0;
      rsp_count_q <= '0;
      state_q     <= IDLE;
      tx_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
    end else begin
      cmd_data_q  <= cmd_data_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      cmd_wr_q    <= cmd_wr_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_count_q <= cmd_count_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_count_q <= rsp_count_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
    end
  end

  assign host.cmd_ready = cmd_ready_w;
  assign host.rsp_valid = rsp_valid_w;
  assign host.rsp_data  = rsp_data_q[rsp_rd_q];
  assign host.rsp_addr  = rsp_addr_q[rsp_rd_q];

  assign cmd_count            = cmd_count_q;
  assign rsp_count            = rsp_count_q;
  assign m_start_trans        = (state_q == LAUNCH);
  assign m_tx_data            = tx_q;
  assign m_chipADDRS          = addr_q;
  assign m_transaction_length = len_q;

endmodule
